// File: rtl/pattern_seq_pkg.sv
// Shared types, defaults and helpers for the programmable pattern sequencer.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_OUT_W = 1;

  // Active sequence length: zero runs a single entry, oversize runs the whole table.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/pattern_regfile.sv
// Pattern table: one write port, one combinational read port with write-through bypass.
module pattern_regfile
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned OUT_W = DEF_OUT_W,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  logic [OUT_W-1:0] mem_q [DEPTH];

  // Addresses with no matching entry simply hit nothing, so out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == IDX_W'(i)) mem_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == IDX_W'(i)) begin
        rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[i];
      end
    end
  end

endmodule

// File: rtl/pattern_seq_fsm.sv
// Moore pattern sequencer stepping through a runtime-writable table in loop or one-shot mode.
module pattern_seq_fsm
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned OUT_W = DEF_OUT_W,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned LEN_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             one_shot,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  output logic [OUT_W-1:0] out1,
  output logic [IDX_W-1:0] state_idx,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] rd_data;
  logic             last_idx;

  assign last_idx = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  // Table is read at the next index so the registered output lines up with state_idx.
  pattern_regfile #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= LEN_W'(1);
      mode_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Next state, index and pulse decisions; stop outranks hold, start is ignored in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (start && !stop) begin
          state_d = ST_RUN;
          len_d   = LEN_W'(clamp_len(32'(seq_len), DEPTH));
          mode_d  = one_shot;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (last_idx) begin
            idx_d = '0;
            if (mode_q) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              wrap_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_d = '0;
    if (state_d == ST_RUN) out_d = rd_data;
  end

  assign out1      = out_q;
  assign state_idx = idx_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule
